// File: rtl/seq_sub_pkg.sv
// Shared constants for the nibble-serial subtractor: FSM state encoding and slice width.
package seq_sub_pkg;
  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/sub4_slice.sv
// Combinational 4-bit subtract with borrow: {b, n} = a - c - bi.
import seq_sub_pkg::*;

module sub4_slice (
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] c,
  input  logic             bi,
  output logic [NIB_W-1:0] n,
  output logic             b
);
  logic [NIB_W:0] diff;

  // The extra top bit of the 5-bit wrap-around result is exactly the borrow out.
  assign diff = {1'b0, a} - {1'b0, c} - {{NIB_W{1'b0}}, bi};
  assign n    = diff[NIB_W-1:0];
  assign b    = diff[NIB_W];
endmodule

// File: rtl/seq_sub16_nibble.sv
// Nibble-serial D = X - Y - BIN: one 4-bit slice per clock, result after WIDTH/4 cycles.
// Single operation in flight; results are held in DONE until out_ready.
import seq_sub_pkg::*;

module seq_sub16_nibble #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);
  localparam int NN = WIDTH / NIB_W;
  localparam int KW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NN - 1);

  state_t     state;
  logic [KW-1:0] k;
  logic [WIDTH-1:0] x_reg;
  logic [WIDTH-1:0] y_reg;
  logic       borrow_reg;

  logic [NN-1:0][NIB_W-1:0] x_nib;
  logic [NN-1:0][NIB_W-1:0] y_nib;
  logic [NIB_W-1:0] slice_n;
  logic             slice_b;

  assign x_nib = x_reg;
  assign y_nib = y_reg;

  sub4_slice u_slice (
    .a  (x_nib[k]),
    .c  (y_nib[k]),
    .bi (borrow_reg),
    .n  (slice_n),
    .b  (slice_b)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= IDLE;
      k          <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      borrow_reg <= 1'b0;
      d          <= '0;
      bout       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_reg      <= x;
            y_reg      <= y;
            borrow_reg <= bin;
            d          <= '0;
            k          <= '0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          d[k*NIB_W +: NIB_W] <= slice_n;
          borrow_reg          <= slice_b;
          if (k == K_LAST) begin
            // slice_n[3] is the final d MSB being written this cycle.
            bout  <= slice_b;
            ovf   <= (x_reg[WIDTH-1] != y_reg[WIDTH-1]) && (slice_n[NIB_W-1] != x_reg[WIDTH-1]);
            k     <= '0;
            state <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
